// File: rtl/down_cntr_pkg.sv
// Shared types and default widths for the loadable down-counter/timer.
package down_cntr_pkg;

  localparam int unsigned N_DEF    = 8;
  localparam int unsigned PS_W_DEF = 4;

  // FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage : down_cntr_pkg

// File: rtl/down_cntr_prescaler.sv
// Tick prescaler: one tick every div+1 enabled cycles.
// Compiled only when DOWN_CNTR_PRESCALE_EN is defined.
`ifdef DOWN_CNTR_PRESCALE_EN
module down_cntr_prescaler
  import down_cntr_pkg::*;
#(
  parameter int unsigned PS_W = PS_W_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clr,
  input  logic            en,
  input  logic [PS_W-1:0] div,
  output logic            tick
);

  logic [PS_W-1:0] r_cnt;

  // Tick on the last cycle of each div+1 window
  assign tick = en && (r_cnt == div);

  // Window counter; restarts whenever control activity is seen
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (r_cnt == div) r_cnt <= '0;
      else              r_cnt <= r_cnt + PS_W'(1);
    end
  end

endmodule : down_cntr_prescaler
`endif

// File: rtl/down_cntr_timer.sv
// Loadable N-bit down-counter/timer with one-shot / auto-reload modes,
// start/stop control and a registered 1-cycle terminal-count pulse.
// Optional tick prescaler (and ps_div port) under DOWN_CNTR_PRESCALE_EN.
module down_cntr_timer
  import down_cntr_pkg::*;
#(
  parameter int unsigned N = N_DEF
`ifdef DOWN_CNTR_PRESCALE_EN
  ,
  parameter int unsigned PS_W = PS_W_DEF
`endif
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic [N-1:0]    load_val,
  input  logic            start,
  input  logic            stop,
  input  logic            auto_reload,
`ifdef DOWN_CNTR_PRESCALE_EN
  input  logic [PS_W-1:0] ps_div,
`endif
  output logic [N-1:0]    cntr_out,
  output logic            busy,
  output logic            tc
);

  state_t       r_state, w_state_nxt;
  logic [N-1:0] r_cntr, w_cntr_nxt;
  logic [N-1:0] r_reload, w_reload_nxt;
  logic         r_tc, w_tc_nxt;
  logic         r_busy;
  logic         w_tick;
  logic         w_run;

  assign w_run = (r_state == ST_RUN);

`ifdef DOWN_CNTR_PRESCALE_EN
  // Count tick generator; any control strobe restarts the divide window
  down_cntr_prescaler #(.PS_W(PS_W)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start | stop | load),
    .en      (w_run),
    .div     (ps_div),
    .tick    (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  // State, count, reload and pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cntr   <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cntr   <= w_cntr_nxt;
      r_reload <= w_reload_nxt;
      r_tc     <= w_tc_nxt;
      r_busy   <= (w_state_nxt == ST_RUN);
    end
  end

  // Next-state and datapath; stop overrides load, load overrides start
  always_comb begin
    w_state_nxt  = r_state;
    w_cntr_nxt   = r_cntr;
    w_reload_nxt = r_reload;
    w_tc_nxt     = 1'b0;
    if (stop) begin
      if (w_run) w_state_nxt = ST_IDLE;
    end else begin
      if (load) begin
        w_reload_nxt = load_val;
        if (!w_run) begin
          w_cntr_nxt  = load_val;
          w_state_nxt = ST_IDLE;
        end
      end else if (start && !w_run) begin
        if ((r_cntr != '0) || auto_reload) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_tc_nxt    = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      // Counting continues through a load in RUN; new reload waits for the next wrap
      if (w_run && w_tick) begin
        if (r_cntr == N'(1)) begin
          w_tc_nxt = 1'b1;
          if (auto_reload) begin
            w_cntr_nxt = r_reload;
          end else begin
            w_cntr_nxt  = '0;
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_cntr_nxt = r_cntr - N'(1);
        end
      end
    end
  end

  assign cntr_out = r_cntr;
  assign busy     = r_busy;
  assign tc       = r_tc;

endmodule : down_cntr_timer

// File: tb/tb_down_cntr_timer.sv
// Directed self-checking bench for down_cntr_timer (N=8).
`timescale 1ns/1ps
module tb_down_cntr_timer;

  logic       clk;
  logic       reset_n;
  logic       load;
  logic [7:0] load_val;
  logic       start;
  logic       stop;
  logic       auto_reload;
`ifdef DOWN_CNTR_PRESCALE_EN
  logic [3:0] ps_div;
`endif
  logic [7:0] cntr_out;
  logic       busy;
  logic       tc;

  int n_tests;
  int n_fail;

  down_cntr_timer #(.N(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
`ifdef DOWN_CNTR_PRESCALE_EN
    .ps_div      (ps_div),
`endif
    .cntr_out    (cntr_out),
    .busy        (busy),
    .tc          (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1ns past the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; idle_inputs(); load_val = 8'd0; auto_reload = 1'b0;
`ifdef DOWN_CNTR_PRESCALE_EN
    ps_div = 4'd0;
`endif
    cyc(); cyc();
    n_tests++;
    if ({cntr_out, busy, tc} !== {8'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset cntr=%0d busy=%b tc=%b exp 0/0/0", cntr_out, busy, tc);
    end
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_oneshot();
    logic [7:0] exp_c [5] = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
    logic       exp_b [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    load = 1'b1; load_val = 8'd3; auto_reload = 1'b0;
    cyc();
    load = 1'b0;
    n_tests++;
    if ({cntr_out, busy, tc} !== {8'd3, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL oneshot_load cntr=%0d busy=%b tc=%b exp 3/0/0", cntr_out, busy, tc);
    end
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      start = 1'b0;
      n_tests++;
      if ({cntr_out, busy, tc} !== {exp_c[i], exp_b[i], exp_t[i]}) begin
        n_fail++;
        $display("FAIL oneshot_step%0d cntr=%0d busy=%b tc=%b exp %0d/%b/%b",
                 i, cntr_out, busy, tc, exp_c[i], exp_b[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_auto_reload();
    logic [7:0] exp_c [9] = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1, 8'd4};
    logic       exp_t [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    load = 1'b1; load_val = 8'd4; auto_reload = 1'b1;
    cyc();
    load = 1'b0; start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      start = 1'b0;
      n_tests++;
      if ({cntr_out, busy, tc} !== {exp_c[i], 1'b1, exp_t[i]}) begin
        n_fail++;
        $display("FAIL auto_step%0d cntr=%0d busy=%b tc=%b exp %0d/1/%b",
                 i, cntr_out, busy, tc, exp_c[i], exp_t[i]);
      end
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    n_tests++;
    if ({cntr_out, busy, tc} !== {8'd4, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL auto_stop cntr=%0d busy=%b tc=%b exp 4/0/0", cntr_out, busy, tc);
    end
  endtask

  task automatic test_stop_resume();
    int bad;
    load = 1'b1; load_val = 8'd3; auto_reload = 1'b0;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if ({cntr_out, busy, tc} !== {8'd2, 1'b0, 1'b0}) bad++;
      cyc();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stop_hold bad_cycles=%0d last cntr=%0d busy=%b exp 2/0", bad, cntr_out, busy);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_tests++;
    if ({cntr_out, busy, tc} !== {8'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL resume_start cntr=%0d busy=%b tc=%b exp 2/1/0", cntr_out, busy, tc);
    end
    cyc();
    n_tests++;
    if ({cntr_out, busy, tc} !== {8'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL resume_dec cntr=%0d busy=%b tc=%b exp 1/1/0", cntr_out, busy, tc);
    end
    cyc();
    n_tests++;
    if ({cntr_out, busy, tc} !== {8'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL resume_tc cntr=%0d busy=%b tc=%b exp 0/0/1", cntr_out, busy, tc);
    end
  endtask

  task automatic test_zero_load();
    int bad;
    load = 1'b1; load_val = 8'd0; auto_reload = 1'b0;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    n_tests++;
    if ({cntr_out, busy, tc} !== {8'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_oneshot_tc cntr=%0d busy=%b tc=%b exp 0/0/1", cntr_out, busy, tc);
    end
    cyc();
    n_tests++;
    if ({cntr_out, busy, tc} !== {8'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL zero_oneshot_nowrap cntr=%0d busy=%b tc=%b exp 0/0/0", cntr_out, busy, tc);
    end
    auto_reload = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    n_tests++;
    if ({cntr_out, busy, tc} !== {8'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL zero_auto_start cntr=%0d busy=%b tc=%b exp 0/1/0", cntr_out, busy, tc);
    end
    bad = 0;
    for (int i = 1; i <= 255; i++) begin
      cyc();
      if ({cntr_out, busy, tc} !== {8'(256 - i), 1'b1, 1'b0}) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL zero_auto_wrap bad_cycles=%0d last cntr=%0d exp 1", bad, cntr_out);
    end
    cyc();
    n_tests++;
    if ({cntr_out, busy, tc} !== {8'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_auto_period cntr=%0d busy=%b tc=%b exp 0/1/1", cntr_out, busy, tc);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_priority();
    load = 1'b1; load_val = 8'd5; auto_reload = 1'b1;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    stop = 1'b1; load = 1'b1; load_val = 8'd9; start = 1'b1;
    cyc();
    idle_inputs();
    n_tests++;
    if ({cntr_out, busy, tc} !== {8'd4, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL prio_stop cntr=%0d busy=%b tc=%b exp 4/0/0", cntr_out, busy, tc);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    n_tests++;
    if ({cntr_out, busy, tc} !== {8'd5, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL prio_noload cntr=%0d busy=%b tc=%b exp 5/1/1", cntr_out, busy, tc);
    end
    cyc(); cyc(); cyc(); cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    n_tests++;
    if ({cntr_out, busy, tc} !== {8'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL stop_terminal cntr=%0d busy=%b tc=%b exp 1/0/0", cntr_out, busy, tc);
    end
  endtask

  task automatic test_load_in_run();
    load = 1'b1; load_val = 8'd3; auto_reload = 1'b1;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0; load = 1'b1; load_val = 8'd6;
    cyc();
    load = 1'b0;
    n_tests++;
    if ({cntr_out, busy, tc} !== {8'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL run_load_keeps_count cntr=%0d busy=%b tc=%b exp 2/1/0", cntr_out, busy, tc);
    end
    cyc(); cyc();
    n_tests++;
    if ({cntr_out, busy, tc} !== {8'd6, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL run_load_next_reload cntr=%0d busy=%b tc=%b exp 6/1/1", cntr_out, busy, tc);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_async_reset();
    load = 1'b1; load_val = 8'd5; auto_reload = 1'b0;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    n_tests++;
    if ({cntr_out, busy} !== {8'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL areset_setup cntr=%0d busy=%b exp 5/1", cntr_out, busy);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({cntr_out, busy, tc} !== {8'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL areset_immediate cntr=%0d busy=%b tc=%b exp 0/0/0", cntr_out, busy, tc);
    end
    #1 reset_n = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_tests++;
    if ({cntr_out, busy, tc} !== {8'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL areset_reload_cleared cntr=%0d busy=%b tc=%b exp 0/0/1", cntr_out, busy, tc);
    end
    cyc();
  endtask

`ifdef DOWN_CNTR_PRESCALE_EN
  task automatic test_prescale();
    logic [7:0] exp_c [7] = '{8'd2, 8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd0};
    logic       exp_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ps_div = 4'd2;
    load = 1'b1; load_val = 8'd2; auto_reload = 1'b0;
    cyc();
    load = 1'b0; start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      start = 1'b0;
      n_tests++;
      if ({cntr_out, tc} !== {exp_c[i], exp_t[i]}) begin
        n_fail++;
        $display("FAIL prescale_clk%0d cntr=%0d tc=%b exp %0d/%b",
                 i, cntr_out, tc, exp_c[i], exp_t[i]);
      end
    end
    ps_div = 4'd0;
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_oneshot();
    test_auto_reload();
    test_stop_resume();
    test_zero_load();
    test_priority();
    test_load_in_run();
    test_async_reset();
`ifdef DOWN_CNTR_PRESCALE_EN
    test_prescale();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Run-time bound in case a sequence never completes
  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule : tb_down_cntr_timer
